// File: rtl/alu_pkg.sv
// Shared constants for the ALU extender pipeline: opcode encodings formed as
// {M,S1,S0} and bit positions inside the 4-bit flags word {C,Z,N,V}.
package alu_pkg;

    // Logic group (M=0)
    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    // Arithmetic group (M=1)
    localparam logic [2:0] OP_DEC = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_INC = 3'b111;

    // Flag bit indices within flags = {C,Z,N,V}
    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_operand_extender.sv
// Combinational operand extender: maps (M,S1,S0,a,b) to the adder inputs
// X, Y and carry-in c0. Each bit is an independent copy of the classic 1-bit
// arithmetic/logic extender cell; logic results travel through the adder as
// X + 0 + 0.
module alu_operand_extender
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             M,
    input  logic             S1,
    input  logic             S0,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             c0
);

    logic [2:0] op;
    assign op = {M, S1, S0};

    // Carry-in is only set for SUB (two's complement) and INC
    assign c0 = M & S1;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic x_bit;
            logic y_bit;

            // Per-bit extender cell
            always_comb begin
                x_bit = a[gi];
                y_bit = 1'b0;
                case (op)
                    OP_NOT: x_bit = ~a[gi];
                    OP_AND: x_bit = a[gi] & b[gi];
                    OP_OR:  x_bit = a[gi] | b[gi];
                    OP_XOR: x_bit = a[gi] ^ b[gi];
                    OP_DEC: y_bit = 1'b1;
                    OP_ADD: y_bit = b[gi];
                    OP_SUB: y_bit = ~b[gi];
                    OP_INC: y_bit = 1'b0;
                    default: begin
                        x_bit = a[gi];
                        y_bit = 1'b0;
                    end
                endcase
            end

            assign x[gi] = x_bit;
            assign y[gi] = y_bit;
        end
    endgenerate

endmodule

// File: rtl/alu_extender_pipe.sv
// Two-stage ALU datapath with valid/ready handshakes.
//   Stage 1 registers the extended operands (X, Y, c0) and the M bit.
//   Stage 2 adds them, derives C/Z/N/V and holds result/flags until consumed.
// Optional build macro: ALU_SAT_EN -- arithmetic ops saturate on signed
// overflow (0x7F.. / 0x80..) instead of wrapping; V still reports overflow.
module alu_extender_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             M,
    input  logic             S1,
    input  logic             S0,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    logic [WIDTH-1:0] ext_x;
    logic [WIDTH-1:0] ext_y;
    logic             ext_c0;

    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_x_reg;
    logic [WIDTH-1:0] s1_y_reg;
    logic             s1_c0_reg;
    logic             s1_m_reg;

    logic             s2_valid_reg;
    logic [WIDTH-1:0] s2_result_reg;
    logic [3:0]       s2_flags_reg;

    logic             s2_adv;
    logic             s1_adv;
    logic             in_fire;

    logic [WIDTH:0]   sum_full;
    logic             ovf;
    logic [WIDTH-1:0] result_next;
    logic [3:0]       flags_next;

    alu_operand_extender #(.WIDTH(WIDTH)) u_extender (
        .M  (M),
        .S1 (S1),
        .S0 (S0),
        .a  (a),
        .b  (b),
        .x  (ext_x),
        .y  (ext_y),
        .c0 (ext_c0)
    );

    // A stage may load when it is empty or its contents move on this cycle
    assign s2_adv   = !s2_valid_reg || out_ready;
    assign s1_adv   = !s1_valid_reg || s2_adv;
    assign in_ready = s1_adv;
    assign in_fire  = in_valid && s1_adv;

    // Stage 1: capture extended operands on an input handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_x_reg     <= '0;
            s1_y_reg     <= '0;
            s1_c0_reg    <= 1'b0;
            s1_m_reg     <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_reg <= in_valid;
            if (in_fire) begin
                s1_x_reg  <= ext_x;
                s1_y_reg  <= ext_y;
                s1_c0_reg <= ext_c0;
                s1_m_reg  <= M;
            end
        end
    end

    // Adder and flag derivation on the stage-1 contents
    always_comb begin
        sum_full = {1'b0, s1_x_reg} + {1'b0, s1_y_reg} + {{WIDTH{1'b0}}, s1_c0_reg};
        // Same-sign operands producing an opposite-sign sum; carry-in cannot break this rule
        ovf = s1_m_reg
            && (s1_x_reg[WIDTH-1] == s1_y_reg[WIDTH-1])
            && (sum_full[WIDTH-1] != s1_x_reg[WIDTH-1]);
        result_next = sum_full[WIDTH-1:0];
`ifdef ALU_SAT_EN
        // Overflow direction follows the (shared) operand sign
        if (ovf) begin
            result_next = s1_x_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                            : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        flags_next         = 4'b0000;
        flags_next[FLAG_C] = s1_m_reg & sum_full[WIDTH];
        flags_next[FLAG_Z] = (result_next == '0);
        flags_next[FLAG_N] = result_next[WIDTH-1];
        flags_next[FLAG_V] = ovf;
    end

    // Stage 2: hold result and flags until the consumer takes them
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_reg  <= 1'b0;
            s2_result_reg <= '0;
            s2_flags_reg  <= 4'b0000;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_result_reg <= result_next;
                s2_flags_reg  <= flags_next;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign result    = s2_result_reg;
    assign flags     = s2_flags_reg;

endmodule

// File: tb/tb_alu_extender_pipe.sv
// Scoreboard bench for alu_extender_pipe (WIDTH=8): expectations are pushed at
// accept time and popped when the DUT hands a result over.
module tb_alu_extender_pipe;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             M;
    logic             S1;
    logic             S0;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;

    typedef struct {
        logic [7:0] res;
        logic [3:0] fl;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   lat_en   = 1'b0;

    alu_extender_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .M         (M),
        .S1        (S1),
        .S0        (S0),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model written straight from the op table, using signed integer ranges
    function automatic void model(input logic [2:0] op, input logic [7:0] ia, input logic [7:0] ib,
                                  output logic [7:0] f, output logic [3:0] fl);
        int         sa;
        int         sb;
        int         sres;
        logic [8:0] u;
        logic       arith;
        logic       c;
        logic       v;
        sa    = $signed(ia);
        sb    = $signed(ib);
        sres  = 0;
        arith = op[2];
        case (op)
            3'b000: u = {1'b0, ~ia};
            3'b001: u = {1'b0, ia & ib};
            3'b010: u = {1'b0, ia | ib};
            3'b011: u = {1'b0, ia ^ ib};
            3'b100: begin u = {1'b0, ia} + 9'h0FF; sres = sa - 1; end
            3'b101: begin u = {1'b0, ia} + {1'b0, ib}; sres = sa + sb; end
            3'b110: begin u = {1'b0, ia} + {1'b0, ~ib} + 9'd1; sres = sa - sb; end
            default: begin u = {1'b0, ia} + 9'd1; sres = sa + 1; end
        endcase
        c = arith & u[8];
        v = arith && (sres > 127 || sres < -128);
        f = u[7:0];
`ifdef ALU_SAT_EN
        if (v) f = (sres > 0) ? 8'h7F : 8'h80;
`endif
        fl = {c, (f == 8'h00), f[7], v};
    endfunction

    // Output side of the scoreboard: one line per completed transaction
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", {31'b0, out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                $display("out: result=%02h flags=%04b (exp %02h %04b) cyc=%0d", result, flags, e.res, e.fl, cyc);
                check("result", {24'b0, result}, {24'b0, e.res});
                check("flags", {28'b0, flags}, {28'b0, e.fl});
                if (lat_en) check("latency", cyc - e.cyc, 32'd2);
            end
        end
    end

    // Drive an op and hold it until accepted; expectation is pushed on accept
    task automatic send(input logic [2:0] op, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [7:0] ef, input logic [3:0] efl);
        bit   ok;
        exp_t e;
        {M, S1, S0} = op;
        a        = ia;
        b        = ib;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            if (ok) begin
                e.res = ef;
                e.fl  = efl;
                e.cyc = cyc;
                q.push_back(e);
                $display("in : op=%03b a=%02h b=%02h cyc=%0d", op, ia, ib, cyc);
            end
            @(posedge clk);
            #1;
        end
        if (!ok) check("accept_timeout", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic send_model(input logic [2:0] op, input logic [7:0] ia, input logic [7:0] ib);
        logic [7:0] f;
        logic [3:0] fl;
        model(op, ia, ib, f, fl);
        send(op, ia, ib, f, fl);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", q.size(), 32'd0);
    endtask

    initial begin
        logic [7:0] r0;
        logic [3:0] f0;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        {M, S1, S0} = 3'b000;
        a = 8'h00;
        b = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", {24'b0, result}, 32'd0);
        check("rst_flags", {28'b0, flags}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Full op sweep at full rate with latency checks
        lat_en = 1'b1;
        for (int op = 0; op < 8; op++) begin
            for (int k = 0; k < 4; k++) begin
                send_model(3'(op), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            end
        end

        // Directed corner cases with hand-derived expectations
`ifdef ALU_SAT_EN
        send(3'b101, 8'h7F, 8'h01, 8'h7F, 4'b0001);
`else
        send(3'b101, 8'h7F, 8'h01, 8'h80, 4'b0011);
`endif
        send(3'b110, 8'h05, 8'h05, 8'h00, 4'b1100);
        send(3'b100, 8'h00, 8'h00, 8'hFF, 4'b0010);
        send(3'b111, 8'hFF, 8'h00, 8'h00, 4'b1100);
        send(3'b011, 8'hAA, 8'hFF, 8'h55, 4'b0000);
        send(3'b000, 8'h0F, 8'h00, 8'hF0, 4'b0010);
        drain();
        lat_en = 1'b0;

        // Backpressure: two ops fill the pipe, the third is refused
        out_ready = 1'b0;
        send_model(3'b101, 8'h11, 8'h22);
        send_model(3'b110, 8'h40, 8'h50);
        {M, S1, S0} = 3'b111;
        a = 8'h33;
        b = 8'h00;
        in_valid = 1'b1;
        @(negedge clk);
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        check("bp_out_valid", {31'b0, out_valid}, 32'd1);
        r0 = result;
        f0 = flags;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready_hold", {31'b0, in_ready}, 32'd0);
            check("bp_result_stable", {24'b0, result}, {24'b0, r0});
            check("bp_flags_stable", {28'b0, flags}, {28'b0, f0});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_model(3'b111, 8'h33, 8'h00);
        send_model(3'b001, 8'h3C, 8'h0F);
        drain();

        // Reset with two ops in flight
        out_ready = 1'b0;
        send_model(3'b101, 8'h01, 8'h02);
        send_model(3'b101, 8'h03, 8'h04);
        rst      = 1'b1;
        in_valid = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_result", {24'b0, result}, 32'd0);
        check("mid_rst_flags", {28'b0, flags}, 32'd0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst       = 1'b0;
        out_ready = 1'b1;
        idle(5);
        check("post_rst_out_valid", {31'b0, out_valid}, 32'd0);

        // Pipeline still works after the flush
        lat_en = 1'b1;
        send_model(3'b110, 8'h80, 8'h01);
        send_model(3'b010, 8'hA0, 8'h05);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
